// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the sequential BCD to excess-3 converter.
package bcd_xs3_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] XS3_BIAS = 4'd3;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_xs3_digit.sv
// Single-digit BCD to excess-3 converter; codes above 9 wrap mod 16 and are flagged.
module bcd_xs3_digit
  import bcd_xs3_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] x,
  output logic               invalid
);
  assign x       = d + XS3_BIAS;
  assign invalid = (d > BCD_MAX);
endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Word-level BCD to excess-3 sequencer: one shared digit converter, one digit per clock, LSD first.
module bcd_xs3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_xs3,
  output logic [DIGITS-1:0]         out_err_mask,
  output logic                      busy
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q;
  logic [DIGIT_W*DIGITS-1:0]   src_q;
  logic [DIGIT_W*DIGITS-1:0]   res_q;
  logic [DIGITS-1:0]           err_q;
  logic [DIGIT_W-1:0]          digit_d;
  logic [DIGIT_W-1:0]          digit_x;
  logic                        digit_inv;
  logic                        accept;

  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    digit_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit_d = src_q[i*DIGIT_W +: DIGIT_W];
    end
  end

  bcd_xs3_digit u_digit (
    .d       (digit_d),
    .x       (digit_x),
    .invalid (digit_inv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshake outputs decode from state only, so no input-to-output path exists.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        if (idx_q == IDX_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      src_q <= '0;
      res_q <= '0;
      err_q <= '0;
    end else if (accept) begin
      src_q <= in_bcd;
      res_q <= '0;
      err_q <= '0;
      idx_q <= '0;
    end else if (state_q == CONV) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          res_q[i*DIGIT_W +: DIGIT_W] <= digit_x;
          err_q[i]                    <= digit_inv;
        end
      end
      if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign out_xs3      = res_q;
  assign out_err_mask = err_q;
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Directed bench for bcd_xs3_seq_ctrl with a queue scoreboard checked at each output handshake.
module tb_bcd_xs3_seq_ctrl;
  localparam int DIGITS = 4;

  typedef struct packed {
    logic [15:0] xs3;
    logic [3:0]  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bcd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_xs3;
  logic [3:0]  out_err_mask;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t sb[$];

  bcd_xs3_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bcd       (in_bcd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_xs3      (out_xs3),
    .out_err_mask (out_err_mask),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Model: independent per-digit excess-3 reference.
  function automatic exp_t model(input logic [15:0] bcd);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      d = bcd[i*4 +: 4];
      e.xs3[i*4 +: 4] = 4'((int'(d) + 3) % 16);
      e.mask[i] = (int'(d) >= 10);
    end
    return e;
  endfunction

  // Compare at the cycle before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {48'h0, out_xs3}, 64'hdead);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_xs3", {48'h0, out_xs3}, {48'h0, e.xs3});
        chk("out_err_mask", {60'h0, out_err_mask}, {60'h0, e.mask});
      end
    end
  end

  // Called at #1 after an edge; returns at #1 after the accept edge.
  task automatic send(input logic [15:0] bcd, input bit push, input bit hold);
    int n;
    in_bcd = bcd;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
    if (push) sb.push_back(model(bcd));
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 64'(n), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int first_acc;
    #2;
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_busy", {63'h0, busy}, 64'd0);
    chk("rst_out_xs3", {48'h0, out_xs3}, 64'd0);
    chk("rst_mask", {60'h0, out_err_mask}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: latency and word period.
    send(16'h1234, 1'b1, 1'b0);
    first_acc = acc_cyc;
    chk("busy_in_conv", {63'h0, busy}, 64'd1);
    chk("in_ready_in_conv", {63'h0, in_ready}, 64'd0);
    wait_out(lat);
    chk("latency", 64'(lat), 64'd4);

    // Scenario 2: illegal digits.
    send(16'h9A00, 1'b1, 1'b0);
    chk("word_period", 64'(acc_cyc - first_acc), 64'd6);
    send(16'hFFFF, 1'b1, 1'b0);
    drain();

    // Scenario 3: backpressure.
    out_ready = 1'b0;
    send(16'h0909, 1'b1, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {63'h0, out_valid}, 64'd1);
      chk("bp_out_xs3", {48'h0, out_xs3}, 64'h3C3C);
      chk("bp_in_ready", {63'h0, in_ready}, 64'd0);
      chk("bp_busy", {63'h0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {63'h0, in_ready}, 64'd1);
    drain();

    // Scenario 4: in_valid during CONV is ignored.
    send(16'h0042, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_bcd = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Scenario 5: asynchronous reset mid-conversion.
    send(16'h5678, 1'b0, 1'b0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("async_rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("async_rst_busy", {63'h0, busy}, 64'd0);
    chk("async_rst_out_xs3", {48'h0, out_xs3}, 64'd0);
    chk("async_rst_mask", {60'h0, out_err_mask}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 1'b1, 1'b0);
    drain();

    // Scenario 6: back-to-back with in_valid held.
    send(16'h0000, 1'b1, 1'b1);
    send(16'h9999, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
